// File: rtl/irq_vector_ctl_if.sv
// irq_vector_ctl_if: CPU bus view seen by the vectored interrupt controller.
// The master drives the address phase; the slave returns the DI override.
interface irq_vector_ctl_if;
  logic [15:0] AD;
  logic        WE;
  logic [7:0]  WD;
  logic        RDY;
  logic        VOE;
  logic [7:0]  VO;

  modport master (
    output AD, WE, WD, RDY,
    input  VOE, VO
  );

  modport slave (
    input  AD, WE, WD, RDY,
    output VOE, VO
  );
endinterface

// File: rtl/irq_vector_ctl.sv
// irq_vector_ctl: masked edge/level interrupt channels for the 65C02 core.
// Combines requests into IRQ and replaces the FFFE/FFFF fetch with a vector.
module irq_vector_ctl #(
  parameter int          NCH      = 8,
  parameter logic [15:0] REG_BASE = 16'hFE00,
  parameter logic [15:0] VEC_BASE = 16'hFF00
) (
  input  logic            clk,
  input  logic            RST,
  irq_vector_ctl_if.slave bus,
  input  logic [NCH-1:0]  irq_in,
  output logic            IRQ
);

  typedef enum logic {IDLE, LATCHED} state_t;

  state_t         state, state_n;
  logic [NCH-1:0] mask, edge_r, pend_e, irq_q;
  logic [NCH-1:0] pend, req, rise, w1c, ack;
  logic [2:0]     chan, act_chan;
  logic           act_valid;
  logic           rd, wr, win;
  logic           fetch_lo, fetch_hi;
  logic           rd_hit;
  logic [7:0]     rd_data, reg_data;
  logic [15:0]    vec_lo, vec_hi;

  assign rd   = bus.RDY & ~bus.WE;
  assign wr   = bus.RDY & bus.WE;
  assign win  = bus.AD[15:2] == REG_BASE[15:2];
  assign pend = (pend_e & edge_r) | (irq_in & ~edge_r);
  assign req  = pend & mask;
  assign rise = irq_in & ~irq_q & edge_r;
  assign w1c  = (wr && win && bus.AD[1:0] == 2'd2)
              ? bus.WD[NCH-1:0] : '0;

  always_comb begin
    act_valid = 1'b0;
    act_chan  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        act_valid = 1'b1;
        act_chan  = 3'(i);
      end
    end
  end

  always_comb begin
    state_n  = state;
    fetch_lo = 1'b0;
    fetch_hi = 1'b0;
    if (bus.RDY) begin
      unique case (state)
        IDLE: begin
          if (rd && bus.AD == 16'hFFFE && act_valid) begin
            fetch_lo = 1'b1;
            state_n  = LATCHED;
          end
        end
        LATCHED: begin
          state_n  = IDLE;
          fetch_hi = rd && bus.AD == 16'hFFFF;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++)
      ack[i] = fetch_lo && act_chan == 3'(i);
  end

  assign vec_lo = VEC_BASE + {12'h000, act_chan, 1'b0};
  assign vec_hi = VEC_BASE + {12'h000, chan, 1'b0};

  always_comb begin
    reg_data = '0;
    unique case (bus.AD[1:0])
      2'd0: reg_data = 8'(mask);
      2'd1: reg_data = 8'(edge_r);
      2'd2: reg_data = 8'(pend);
      2'd3: reg_data = {act_valid, 4'b0000, act_chan};
    endcase
  end

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    unique case (1'b1)
      fetch_lo: begin
        rd_hit  = 1'b1;
        rd_data = vec_lo[7:0];
      end
      fetch_hi: begin
        rd_hit  = 1'b1;
        rd_data = vec_hi[15:8];
      end
      (rd && win): begin
        rd_hit  = 1'b1;
        rd_data = reg_data;
      end
      default: rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      chan  <= '0;
    end else begin
      state <= state_n;
      if (fetch_lo)
        chan <= act_chan;
    end
  end

  // A new edge outranks a same-cycle clear from W1C or ack.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      mask    <= '0;
      edge_r  <= '0;
      pend_e  <= '0;
      irq_q   <= '0;
      IRQ     <= 1'b0;
      bus.VOE <= 1'b0;
      bus.VO  <= '0;
    end else begin
      irq_q  <= irq_in;
      IRQ    <= |req;
      pend_e <= ((pend_e & ~(w1c | ack)) | rise) & edge_r;
      if (wr && win && bus.AD[1:0] == 2'd0)
        mask <= bus.WD[NCH-1:0];
      if (wr && win && bus.AD[1:0] == 2'd1)
        edge_r <= bus.WD[NCH-1:0];
      if (bus.RDY) begin
        bus.VOE <= rd_hit;
        bus.VO  <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_irq_vector_ctl.sv
// tb_irq_vector_ctl: directed and random stimulus for irq_vector_ctl,
// checked by a queued reference model and a separate output monitor.
module tb_irq_vector_ctl;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic       IRQ;

  irq_vector_ctl_if bus ();

  irq_vector_ctl #(
    .NCH      (8),
    .REG_BASE (16'hFE00),
    .VEC_BASE (16'hFF00)
  ) dut (
    .clk    (clk),
    .RST    (RST),
    .bus    (bus),
    .irq_in (irq_in),
    .IRQ    (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         irq;
    bit         voe;
    logic [7:0] vo;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;
  bit   rst_v  = 1'b1;
  logic [7:0] irq_v = 8'h00;

  logic [7:0] m_mask, m_edge, m_pend, m_prev;
  bit         m_lat, m_irq, m_voe;
  int         m_chan;
  logic [7:0] m_vo;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_step(
    input logic [15:0] ad, input bit we, input logic [7:0] wd,
    input bit rdy, input logic [7:0] irq, input bit rst);
    logic [7:0]  vis, req;
    logic [15:0] vec;
    int          act;
    bit          val, fetch, clr;
    if (rst) begin
      m_mask = 0; m_edge = 0; m_pend = 0; m_prev = 0;
      m_lat = 0; m_chan = 0; m_irq = 0; m_voe = 0; m_vo = 0;
      return;
    end
    for (int i = 0; i < 8; i++)
      vis[i] = m_edge[i] ? m_pend[i] : irq[i];
    req = vis & m_mask;
    act = -1;
    for (int i = 7; i >= 0; i--)
      if (req[i]) act = i;
    val   = act >= 0;
    fetch = rdy && !we && ad == 16'hFFFE && !m_lat && val;
    if (rdy) begin
      m_voe = 1;
      m_vo  = 0;
      if (fetch) begin
        vec  = 16'hFF00 + 16'(2 * act);
        m_vo = vec[7:0];
      end else if (!we && ad == 16'hFFFF && m_lat) begin
        vec  = 16'hFF00 + 16'(2 * m_chan);
        m_vo = vec[15:8];
      end else if (!we && ad >= 16'hFE00 && ad <= 16'hFE03) begin
        case (ad[1:0])
          2'd0: m_vo = m_mask;
          2'd1: m_vo = m_edge;
          2'd2: m_vo = vis;
          default: m_vo = val ? (8'h80 | 8'(act)) : 8'h00;
        endcase
      end else begin
        m_voe = 0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      clr = (rdy && we && ad == 16'hFE02 && wd[i]) || (fetch && act == i);
      if (!m_edge[i])             m_pend[i] = 0;
      else if (irq[i] && !m_prev[i]) m_pend[i] = 1;
      else if (clr)               m_pend[i] = 0;
    end
    m_irq = val;
    if (rdy) begin
      m_lat = fetch;
      if (fetch) m_chan = act;
    end
    if (rdy && we && ad == 16'hFE00) m_mask = wd;
    if (rdy && we && ad == 16'hFE01) m_edge = wd;
    m_prev = irq;
  endfunction

  task automatic cyc(input logic [15:0] ad, input bit we,
                     input logic [7:0] wd, input bit rdy);
    exp_t e;
    @(negedge clk);
    RST     = rst_v;
    bus.AD  = ad;
    bus.WE  = we;
    bus.WD  = wd;
    bus.RDY = rdy;
    irq_in  = irq_v;
    model_step(ad, we, wd, rdy, irq_v, rst_v);
    e.irq = m_irq;
    e.voe = m_voe;
    e.vo  = m_vo;
    sbq.push_back(e);
    mon_on = 1'b1;
  endtask

  task automatic idle();
    cyc(16'h0000, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wr(input logic [15:0] ad, input logic [7:0] d);
    cyc(ad, 1'b1, d, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [15:0] ad, input logic [7:0] exp,
                        input string name);
    cyc(ad, 1'b0, 8'h00, 1'b1);
    settle();
    chk({name, "_voe"}, 8'(bus.VOE), 8'h01);
    chk(name, bus.VO, exp);
  endtask

  task automatic rd_none(input logic [15:0] ad, input string name);
    cyc(ad, 1'b0, 8'h00, 1'b1);
    settle();
    chk(name, 8'(bus.VOE), 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: no expected entry at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("mon_irq", 8'(IRQ), 8'(e.irq));
          chk("mon_voe", 8'(bus.VOE), 8'(e.voe));
          if (e.voe)
            chk("mon_vo", bus.VO, e.vo);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit          pair_rdy;
    logic [15:0] ad;
    bus.AD  = 16'h0000;
    bus.WE  = 1'b0;
    bus.WD  = 8'h00;
    bus.RDY = 1'b1;

    rst_v = 1'b1;
    idle();
    idle();
    settle();
    chk("rst_irq", 8'(IRQ), 8'h00);
    chk("rst_voe", 8'(bus.VOE), 8'h00);
    chk("rst_vo", bus.VO, 8'h00);
    rst_v = 1'b0;
    rd_chk(16'hFE00, 8'h00, "rst_mask");
    rd_chk(16'hFE01, 8'h00, "rst_edge");
    rd_chk(16'hFE02, 8'h00, "rst_pend");
    rd_chk(16'hFE03, 8'h00, "rst_stat");

    wr(16'hFE01, 8'h01);
    wr(16'hFE00, 8'h01);
    irq_v = 8'h01;
    idle();
    irq_v = 8'h00;
    idle();
    rd_chk(16'hFE02, 8'h01, "edge_pend");
    chk("edge_irq", 8'(IRQ), 8'h01);
    wr(16'hFE02, 8'h01);
    rd_chk(16'hFE02, 8'h00, "w1c_pend");
    chk("w1c_irq", 8'(IRQ), 8'h00);

    wr(16'hFE01, 8'hFF);
    wr(16'hFE00, 8'hFF);
    irq_v = 8'h24;
    idle();
    irq_v = 8'h00;
    idle();
    rd_chk(16'hFFFE, 8'h04, "vec2_lo");
    rd_chk(16'hFFFF, 8'hFF, "vec2_hi");
    rd_chk(16'hFE02, 8'h20, "ack2_pend");
    rd_chk(16'hFE03, 8'h85, "stat5");
    rd_chk(16'hFFFE, 8'h0A, "vec5_lo");
    rd_chk(16'hFFFF, 8'hFF, "vec5_hi");
    rd_chk(16'hFE02, 8'h00, "ack5_pend");

    wr(16'hFE01, 8'h00);
    wr(16'hFE00, 8'h08);
    irq_v = 8'h08;
    idle();
    settle();
    chk("lvl_irq", 8'(IRQ), 8'h01);
    rd_chk(16'hFFFE, 8'h06, "vec3_lo");
    rd_chk(16'hFFFF, 8'hFF, "vec3_hi");
    rd_chk(16'hFE02, 8'h08, "lvl_pend");
    chk("lvl_irq_hold", 8'(IRQ), 8'h01);
    irq_v = 8'h00;
    idle();
    settle();
    chk("lvl_irq_drop", 8'(IRQ), 8'h00);

    rd_none(16'hFFFE, "brk_lo_voe");
    rd_none(16'hFFFF, "brk_hi_voe");
    wr(16'hFE01, 8'hFF);
    wr(16'hFE00, 8'hFF);
    idle();
    irq_v = 8'h02;
    wr(16'hFE02, 8'h02);
    irq_v = 8'h00;
    rd_chk(16'hFE02, 8'h02, "set_wins");

    rd_chk(16'hFE00, 8'hFF, "mask_ff");
    cyc(16'hFFFE, 1'b0, 8'h00, 1'b0);
    settle();
    chk("hold_voe", 8'(bus.VOE), 8'h01);
    chk("hold_vo", bus.VO, 8'hFF);
    cyc(16'hFFFE, 1'b0, 8'h00, 1'b0);
    rd_chk(16'hFE02, 8'h02, "hold_no_ack");
    rd_chk(16'hFFFE, 8'h02, "vec1_lo");
    rst_v = 1'b1;
    idle();
    #1;
    chk("arst_voe", 8'(bus.VOE), 8'h00);
    chk("arst_irq", 8'(IRQ), 8'h00);
    settle();
    rst_v = 1'b0;
    rd_chk(16'hFE02, 8'h00, "arst_pend");

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0)
        irq_v = 8'($urandom);
      case ($urandom_range(0, 9))
        0: wr(16'hFE00 + 16'($urandom_range(0, 2)), 8'($urandom));
        1, 2: cyc(16'hFE00 + 16'($urandom_range(0, 3)), 1'b0, 8'h00,
                  1'b1);
        3, 4, 5: begin
          pair_rdy = $urandom_range(0, 4) != 0;
          cyc(16'hFFFE, 1'b0, 8'h00, pair_rdy);
          pair_rdy = $urandom_range(0, 4) != 0;
          cyc(16'hFFFF, 1'b0, 8'h00, pair_rdy);
        end
        6: begin
          ad = ($urandom_range(0, 1) == 0) ? 16'hFFFE : 16'hFE02;
          cyc(ad, 1'($urandom), 8'($urandom), 1'b0);
        end
        default: cyc(16'h0200 + 16'($urandom_range(0, 255)),
                     1'($urandom), 8'($urandom), 1'b1);
      endcase
    end

    idle();
    @(posedge clk);
    #2;
    mon_on = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
